// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the fabric arbiters.
//   - arb_mode_e : arbitration policy selector (FP / RR / WRR)
//   - lock_st_e  : packet-lock state (open / held by an owner)
//   - onehot2idx : one-hot vector -> binary index
//   - rr_pick    : rotate-priority search starting at a pointer, with wrap
//   Vectors are carried at a fixed maximum width (ARB_MAX_N) so the helpers
//   can live here and be reused by any arbiter with WIDTH <= ARB_MAX_N.
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_FP  = 2'd0,  // fixed priority, lowest index wins
    ARB_RR  = 2'd1,  // round robin, one packet per turn
    ARB_WRR = 2'd2   // weighted round robin, v_weight packets per turn
  } arb_mode_e;

  typedef enum logic {
    LK_OPEN = 1'b0,  // at a packet boundary, free to arbitrate
    LK_HELD = 1'b1   // mid-packet, grant pinned to the owner
  } lock_st_e;

  localparam int ARB_MAX_N = 32;
  localparam int ARB_IDX_W = 5;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

  // OR-reduction of set bit positions; exact for a one-hot input, 0 for zero.
  function automatic arb_idx_t onehot2idx(input arb_vec_t oh);
    arb_idx_t idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | arb_idx_t'(i);
    end
    return idx;
  endfunction

  // First set bit of req[n-1:0] searching upward from ptr and wrapping.
  // Returns a one-hot vector, or zero when no request is set.
  function automatic arb_vec_t rr_pick(input arb_vec_t req, input arb_idx_t ptr,
                                       input int n);
    arb_vec_t gnt;
    logic     found;
    int       pos;
    arb_idx_t sel;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      if (k < n) begin
        pos = int'(ptr) + k;
        if (pos >= n) pos = pos - n;
        sel = arb_idx_t'(pos);
        if (!found && req[sel]) begin
          gnt[sel] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/vrp_reg_slice.sv
// -----------------------------------------------------------------------------
// vrp_reg_slice
//   One-entry valid/ready pipeline register. Full throughput: a new beat is
//   taken in the same cycle the held beat drains. Data is held stable while
//   out_vld & ~out_rdy.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_vld/in_rdy        upstream handshake; in_rdy = ~out_vld | out_rdy
//   in_data  [DW]        upstream data
//   out_vld/out_rdy      downstream handshake
//   out_data [DW]        downstream data, 0 after reset
// -----------------------------------------------------------------------------
module vrp_reg_slice #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data
);

  // Ready never looks at in_vld, so the upstream grant stays rdy-independent.
  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      // NOTE: the data register is reset too, because the output payload must
      // read 0 after reset; a pure datapath register would not need this.
      out_data <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) out_data <= in_data;
    end
  end

endmodule

// File: rtl/arb_wrr_lock.sv
// -----------------------------------------------------------------------------
// arb_wrr_lock
//   N:1 valid/ready arbiter with payload mux, multi-beat packet lock and a
//   choice of fixed-priority, round-robin or weighted round-robin policy.
//   Optional registered output slice (OUT_REG=1) with full throughput.
// Parameters
//   WIDTH      number of input channels (2..32)
//   PLD_WIDTH  payload width
//   MODE       ARB_FP / ARB_RR / ARB_WRR
//   WGT_WIDTH  per-channel WRR weight width
//   OUT_REG    0: combinational output, 1: one-entry registered slice
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   v_vld_s/v_rdy_s/v_last_s per-channel handshake and last-beat flag
//   v_pld_s  [WIDTH]         per-channel payload (unpacked)
//   v_weight [WIDTH]         WRR packets per turn, 0 treated as 1
//   vld_m/rdy_m/pld_m/last_m merged downstream channel
//   gnt_id_m                 source channel of the output beat; present only
//                            when ARB_WRR_LOCK_GNT_ID_EN is defined
// -----------------------------------------------------------------------------
module arb_wrr_lock
  import arb_pkg::*;
#(
  parameter int        WIDTH     = 4,
  parameter int        PLD_WIDTH = 32,
  parameter arb_mode_e MODE      = ARB_RR,
  parameter int        WGT_WIDTH = 4,
  parameter bit        OUT_REG   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_vld_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  input  logic [WIDTH-1:0]     v_last_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s  [WIDTH],
  input  logic [WGT_WIDTH-1:0] v_weight [WIDTH],
  output logic                 vld_m,
  input  logic                 rdy_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic                 last_m
`ifdef ARB_WRR_LOCK_GNT_ID_EN
  ,
  output logic [$clog2(WIDTH)-1:0] gnt_id_m
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  lock_st_e             lock_q, lock_d;
  logic [IDX_W-1:0]     owner_q;      // packet owner; also the WRR turn owner
  logic [IDX_W-1:0]     ptr_q;        // RR search start
  logic [WGT_WIDTH-1:0] credit_q, credit_d;

  logic [WIDTH-1:0]     grant;
  logic [IDX_W-1:0]     gidx;
  logic                 wrr_hold;
  logic                 up_vld;
  logic                 slice_rdy;
  logic                 acc;
  logic                 sel_last;
  logic [PLD_WIDTH-1:0] sel_pld;
  logic [WGT_WIDTH-1:0] wgt_eff;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    if (int'(i) == WIDTH - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Grant: a function of valids and state only, never of rdy_m.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    grant    = '0;
    wrr_hold = 1'b0;
    if (lock_q == LK_HELD) begin
      // Owner keeps the grant even if it drops valid: the gap is a bubble.
      grant = WIDTH'(1) << owner_q;
    end else if (MODE == ARB_FP) begin
      grant = WIDTH'(rr_pick(arb_vec_t'(v_vld_s), '0, WIDTH));
    end else if (MODE == ARB_WRR) begin
      // Turn continues while it has credit and its owner has another packet.
      wrr_hold = (credit_q != '0) && v_vld_s[owner_q];
      if (wrr_hold) grant = WIDTH'(1) << owner_q;
      else          grant = WIDTH'(rr_pick(arb_vec_t'(v_vld_s), arb_idx_t'(ptr_q), WIDTH));
    end else begin
      grant = WIDTH'(rr_pick(arb_vec_t'(v_vld_s), arb_idx_t'(ptr_q), WIDTH));
    end
  end

  assign gidx     = IDX_W'(onehot2idx(arb_vec_t'(grant)));
  assign up_vld   = |(grant & v_vld_s);
  assign sel_pld  = v_pld_s[gidx];
  assign sel_last = v_last_s[gidx];
  assign v_rdy_s  = grant & {WIDTH{slice_rdy}};
  assign acc      = up_vld & slice_rdy;
  assign wgt_eff  = (v_weight[gidx] == '0) ? WGT_WIDTH'(1) : v_weight[gidx];

  // ---------------------------------------------------------------------------
  // Lock FSM and WRR credit next-state.
  // ---------------------------------------------------------------------------
  always_comb begin
    lock_d   = lock_q;
    credit_d = credit_q;
    if (acc) lock_d = sel_last ? LK_OPEN : LK_HELD;
    if (MODE == ARB_WRR) begin
      if (acc && lock_q == LK_OPEN && !wrr_hold) begin
        // New turn: credit from this cycle's weight, minus this packet if it
        // is a single-beat one.
        credit_d = sel_last ? wgt_eff - WGT_WIDTH'(1) : wgt_eff;
      end else if (acc && sel_last) begin
        credit_d = credit_q - WGT_WIDTH'(1);
      end else if (lock_q == LK_OPEN && !wrr_hold) begin
        // Owner absent at a packet boundary: the turn is forfeited.
        credit_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q   <= LK_OPEN;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      lock_q   <= lock_d;
      credit_q <= credit_d;
      if (acc) owner_q <= gidx;
      // ptr always points past the last packet's source; in WRR a held turn
      // simply bypasses it until the turn ends.
      if (acc && sel_last && MODE != ARB_FP) ptr_q <= inc_wrap(gidx);
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage.
  // ---------------------------------------------------------------------------
  if (OUT_REG) begin : g_reg
`ifdef ARB_WRR_LOCK_GNT_ID_EN
    localparam int DW = PLD_WIDTH + 1 + IDX_W;
`else
    localparam int DW = PLD_WIDTH + 1;
`endif
    logic [DW-1:0] din, dout;

`ifdef ARB_WRR_LOCK_GNT_ID_EN
    assign din      = {gidx, sel_last, sel_pld};
    assign gnt_id_m = dout[DW-1 -: IDX_W];
`else
    assign din = {sel_last, sel_pld};
`endif

    vrp_reg_slice #(.DW(DW)) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (up_vld),
      .in_rdy   (slice_rdy),
      .in_data  (din),
      .out_vld  (vld_m),
      .out_rdy  (rdy_m),
      .out_data (dout)
    );

    assign pld_m  = dout[PLD_WIDTH-1:0];
    assign last_m = dout[PLD_WIDTH];
  end else begin : g_comb
    assign slice_rdy = rdy_m;
    assign vld_m     = up_vld;
    // Zero the payload when idle so an ungranted channel never leaks out.
    assign pld_m     = up_vld ? sel_pld : '0;
    assign last_m    = up_vld & sel_last;
`ifdef ARB_WRR_LOCK_GNT_ID_EN
    assign gnt_id_m  = up_vld ? gidx : '0;
`endif
  end

endmodule
